oled_byte_seq: RTL
==================

OLED_BYTE_SEQ -- requirements
Module: oled_byte_seq

Interface
REQ-001 SHALL have parameter RES_LOW_CYC, default 1000, OLED reset-low duration in clk cycles (1 ms at 1 MHz).
REQ-002 SHALL have parameter RES_WAIT_CYC, default 1000, wait after reset release before the first command.
REQ-003 SHALL have parameter FRAME_BYTES, default 1024, data bytes per frame (128x64/8).
REQ-004 SHALL have port clk, input, 1, single system clock (1 MHz), all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port px_valid, input, 1, upstream data byte valid.
REQ-007 SHALL have port px_data, input, 8, upstream display data byte.
REQ-008 SHALL have port px_ready, output, 1, byte accepted when px_valid and px_ready are both high.
REQ-009 SHALL have port spi_ena_write, output, 1, one-cycle start pulse to the SPI byte writer.
REQ-010 SHALL have port spi_data, output, 8, byte presented to the SPI byte writer.
REQ-011 SHALL have port spi_write_done, input, 1, one-cycle completion pulse from the SPI byte writer.
REQ-012 SHALL have port oled_res, output, 1, OLED reset pin, active low.
REQ-013 SHALL have port oled_dc, output, 1, 0 = command, 1 = data.
REQ-014 SHALL have port oled_cs, output, 1, OLED chip select, active low.
REQ-015 SHALL have port init_done, output, 1, high once the init sequence completes, sticky until reset.
REQ-016 SHALL have port frame_done, output, 1, one-cycle pulse after the FRAME_BYTES-th data byte completes.

Function
REQ-017 SHALL implement states RES_LOW, RES_WAIT, CMD_SEND, CMD_WAIT, IDLE, DATA_SEND, DATA_WAIT.
REQ-018 SHALL, in RES_LOW: oled_res=0 for RES_LOW_CYC cycles, then go to RES_WAIT with oled_res=1.
REQ-019 SHALL, in RES_WAIT: count RES_WAIT_CYC cycles, then go to CMD_SEND with cmd index 0.
REQ-020 SHALL, in CMD_SEND: drive spi_data=ROM[idx], oled_dc=0, oled_cs=0, spi_ena_write=1 for exactly one cycle, then go to CMD_WAIT.
REQ-021 SHALL, in CMD_WAIT: hold spi_data, oled_dc and oled_cs stable until spi_write_done, then increment idx; go to CMD_SEND if idx<INIT_LEN-1, else to IDLE with init_done=1.
REQ-022 SHALL assert px_ready only in IDLE; px_ready SHALL be 0 in every other state, including the whole init phase.
REQ-023 SHALL, on px_valid&px_ready in cycle t: register px_data into spi_data and go to DATA_SEND, with spi_ena_write=1, oled_dc=1 and oled_cs=0 in cycle t+1.
REQ-024 SHALL, in DATA_WAIT: hold outputs until spi_write_done, increment the 11-bit byte counter, return to IDLE (px_ready=1 the next cycle), and set oled_cs=1 in IDLE.
REQ-025 SHALL, when the byte counter reaches FRAME_BYTES-1 and completes: wrap it to 0 and pulse frame_done in the same cycle the state returns to IDLE.
REQ-026 SHALL ignore spi_write_done in any state other than CMD_WAIT and DATA_WAIT.
REQ-027 SHALL never assert spi_ena_write in two consecutive cycles.
REQ-028 SHALL, on px_valid asserted during init: not accept the byte, leave the upstream holding it, and accept it in the first IDLE cycle.

Reset
REQ-029 SHALL, on rst_n low and at any time including mid-transfer, immediately force state=RES_LOW, oled_res=0, oled_dc=0, oled_cs=1, spi_ena_write=0, spi_data=8'h00, px_ready=0, init_done=0, frame_done=0, and all counters to 0.
REQ-030 SHALL, after rst_n rises, restart the full init sequence from RES_LOW.

Structure
REQ-031 SHALL place the state encoding, INIT_LEN and the SSD1306 command constants (e.g. 8'hAE display off, 8'hAF display on, 8'h8D charge pump) in shared package oled_pkg.
REQ-032 SHALL take init commands from combinational sub-module oled_init_rom (input idx, output 8-bit cmd), with INIT_LEN entries, first 8'hAE, last 8'hAF.

Verification
REQ-033 SHALL verify reset/init timing: release rst_n -> oled_res low for exactly 1000 cycles, first spi_ena_write exactly 1000 cycles after oled_res rises, spi_data=8'hAE, oled_dc=0.
REQ-034 SHALL verify the init sequence: with the SPI writer model attached, INIT_LEN ena pulses with bytes matching the ROM in order, then init_done=1 and px_ready=1.
REQ-035 SHALL verify a data byte: px_valid=1, px_data=8'hA5 in IDLE -> next cycle spi_ena_write=1, spi_data=8'hA5, oled_dc=1; after write_done, px_ready=1 the next cycle.
REQ-036 SHALL verify frame wrap: stream 1024 bytes -> exactly one frame_done pulse coincident with the return to IDLE after byte 1024; counter=0 before byte 1025.
REQ-037 SHALL verify reset mid-transfer: assert rst_n low during DATA_WAIT -> outputs at reset values within the same cycle; after release, init restarts with oled_res=0.
REQ-038 SHALL verify early valid: px_valid held high from reset -> px_ready stays 0 until init_done; the first data byte is sent only after the last init command.

Source files
------------

// File: rtl/oled_pkg.sv
// ---------------------------------------------------------------------------
// oled_pkg
// Shared definitions for the SSD1306 OLED byte sequencer: FSM state
// encoding, init-sequence length, counter widths and the SSD1306 command
// opcodes used by the init ROM.
// Ports: none (package).
// ---------------------------------------------------------------------------
package oled_pkg;

    typedef enum logic [2:0] {
        ST_RES_LOW   = 3'd0,
        ST_RES_WAIT  = 3'd1,
        ST_CMD_SEND  = 3'd2,
        ST_CMD_WAIT  = 3'd3,
        ST_IDLE      = 3'd4,
        ST_DATA_SEND = 3'd5,
        ST_DATA_WAIT = 3'd6
    } state_t;

    localparam int INIT_LEN   = 25;
    localparam int IDX_W      = 5;
    localparam int BYTE_CNT_W = 11;

    localparam logic [7:0] CMD_DISPLAY_OFF  = 8'hAE;
    localparam logic [7:0] CMD_DISPLAY_ON   = 8'hAF;
    localparam logic [7:0] CMD_CLK_DIV      = 8'hD5;
    localparam logic [7:0] CMD_MUX_RATIO    = 8'hA8;
    localparam logic [7:0] CMD_DISP_OFFSET  = 8'hD3;
    localparam logic [7:0] CMD_START_LINE   = 8'h40;
    localparam logic [7:0] CMD_CHARGE_PUMP  = 8'h8D;
    localparam logic [7:0] CMD_ADDR_MODE    = 8'h20;
    localparam logic [7:0] CMD_SEG_REMAP    = 8'hA1;
    localparam logic [7:0] CMD_COM_SCAN_DEC = 8'hC8;
    localparam logic [7:0] CMD_COM_PINS     = 8'hDA;
    localparam logic [7:0] CMD_CONTRAST     = 8'h81;
    localparam logic [7:0] CMD_PRECHARGE    = 8'hD9;
    localparam logic [7:0] CMD_VCOMH        = 8'hDB;
    localparam logic [7:0] CMD_RESUME_RAM   = 8'hA4;
    localparam logic [7:0] CMD_NORMAL_DISP  = 8'hA6;
    localparam logic [7:0] CMD_NOP          = 8'hE3;

endpackage

// File: rtl/oled_init_rom.sv
// ---------------------------------------------------------------------------
// oled_init_rom
// Combinational SSD1306 power-up command table (128x64, internal charge
// pump, horizontal addressing). Entry 0 turns the display off, the last
// entry turns it on; arguments follow their opcodes.
// Ports:
//   idx  in   command index 0..INIT_LEN-1
//   cmd  out  command/argument byte at idx (NOP beyond the table)
// ---------------------------------------------------------------------------
module oled_init_rom
    import oled_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [7:0]       cmd
);

    always_comb begin
        cmd = CMD_NOP;
        case (idx)
            5'd0:  cmd = CMD_DISPLAY_OFF;
            5'd1:  cmd = CMD_CLK_DIV;
            5'd2:  cmd = 8'h80;
            5'd3:  cmd = CMD_MUX_RATIO;
            5'd4:  cmd = 8'h3F;
            5'd5:  cmd = CMD_DISP_OFFSET;
            5'd6:  cmd = 8'h00;
            5'd7:  cmd = CMD_START_LINE;
            5'd8:  cmd = CMD_CHARGE_PUMP;
            5'd9:  cmd = 8'h14;
            5'd10: cmd = CMD_ADDR_MODE;
            5'd11: cmd = 8'h00;
            5'd12: cmd = CMD_SEG_REMAP;
            5'd13: cmd = CMD_COM_SCAN_DEC;
            5'd14: cmd = CMD_COM_PINS;
            5'd15: cmd = 8'h12;
            5'd16: cmd = CMD_CONTRAST;
            5'd17: cmd = 8'hCF;
            5'd18: cmd = CMD_PRECHARGE;
            5'd19: cmd = 8'hF1;
            5'd20: cmd = CMD_VCOMH;
            5'd21: cmd = 8'h40;
            5'd22: cmd = CMD_RESUME_RAM;
            5'd23: cmd = CMD_NORMAL_DISP;
            5'd24: cmd = CMD_DISPLAY_ON;
            default: cmd = CMD_NOP;
        endcase
    end

endmodule

// File: rtl/oled_byte_seq.sv
// ---------------------------------------------------------------------------
// oled_byte_seq
// Drives an SSD1306 OLED through an external SPI byte writer: hardware
// reset pulse, settle wait, ROM init command stream, then forwards
// upstream display bytes one at a time, pulsing frame_done every
// FRAME_BYTES data bytes.
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   px_valid       in   upstream byte valid
//   px_data[7:0]   in   upstream display byte
//   px_ready       out  byte accepted when px_valid & px_ready
//   spi_ena_write  out  one-cycle start pulse to SPI byte writer
//   spi_data[7:0]  out  byte presented to SPI byte writer
//   spi_write_done in   one-cycle completion pulse from SPI byte writer
//   oled_res       out  OLED reset pin, active low
//   oled_dc        out  0 = command, 1 = data
//   oled_cs        out  OLED chip select, active low
//   init_done      out  sticky high after init sequence
//   frame_done     out  one-cycle pulse after last byte of a frame
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RES_LOW   | oled_res held low for RES_LOW_CYC cycles
// RES_WAIT  | oled_res high, settle RES_WAIT_CYC cycles
// CMD_SEND  | start pulse for init command ROM[idx]
// CMD_WAIT  | wait for writer done, then next command or IDLE
// IDLE      | px_ready high, waiting for an upstream byte
// DATA_SEND | start pulse for the captured data byte
// DATA_WAIT | wait for writer done, count byte, back to IDLE
// ---------------------------------------------------------------------------
module oled_byte_seq
    import oled_pkg::*;
#(
    parameter int RES_LOW_CYC  = 1000,
    parameter int RES_WAIT_CYC = 1000,
    parameter int FRAME_BYTES  = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       px_valid,
    input  logic [7:0] px_data,
    output logic       px_ready,
    output logic       spi_ena_write,
    output logic [7:0] spi_data,
    input  logic       spi_write_done,
    output logic       oled_res,
    output logic       oled_dc,
    output logic       oled_cs,
    output logic       init_done,
    output logic       frame_done
);

    localparam int TMR_MAX = (RES_LOW_CYC > RES_WAIT_CYC) ? RES_LOW_CYC : RES_WAIT_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0]      RES_LOW_TC  = TMR_W'(RES_LOW_CYC - 1);
    localparam logic [TMR_W-1:0]      RES_WAIT_TC = TMR_W'(RES_WAIT_CYC - 1);
    localparam logic [BYTE_CNT_W-1:0] FRAME_TC    = BYTE_CNT_W'(FRAME_BYTES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST    = IDX_W'(INIT_LEN - 1);

    state_t                state_q;
    logic [TMR_W-1:0]      tmr_q;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q;
    logic [7:0]            spi_data_q;
    logic                  ena_q;
    logic                  res_q;
    logic                  dc_q;
    logic                  cs_q;
    logic                  ready_q;
    logic                  init_done_q;
    logic                  frame_done_q;

    logic [IDX_W-1:0]      rom_idx;
    logic [7:0]            rom_cmd;

    assign idx_d = idx_q + IDX_W'(1);

    // The ROM is addressed with the index of the command about to be
    // launched, so the byte can be registered together with the start pulse.
    assign rom_idx = (state_q == ST_CMD_WAIT) ? idx_d : '0;

    oled_init_rom u_rom (
        .idx (rom_idx),
        .cmd (rom_cmd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RES_LOW;
            tmr_q        <= '0;
            idx_q        <= '0;
            byte_cnt_q   <= '0;
            spi_data_q   <= 8'h00;
            ena_q        <= 1'b0;
            res_q        <= 1'b0;
            dc_q         <= 1'b0;
            cs_q         <= 1'b1;
            ready_q      <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            ena_q        <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                ST_RES_LOW: begin
                    if (tmr_q == RES_LOW_TC) begin
                        tmr_q   <= '0;
                        res_q   <= 1'b1;
                        state_q <= ST_RES_WAIT;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                ST_RES_WAIT: begin
                    if (tmr_q == RES_WAIT_TC) begin
                        tmr_q      <= '0;
                        idx_q      <= '0;
                        spi_data_q <= rom_cmd;
                        dc_q       <= 1'b0;
                        cs_q       <= 1'b0;
                        ena_q      <= 1'b1;
                        state_q    <= ST_CMD_SEND;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                ST_CMD_SEND: begin
                    state_q <= ST_CMD_WAIT;
                end
                ST_CMD_WAIT: begin
                    if (spi_write_done) begin
                        idx_q <= idx_d;
                        if (idx_q == IDX_LAST) begin
                            init_done_q <= 1'b1;
                            ready_q     <= 1'b1;
                            cs_q        <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else begin
                            spi_data_q <= rom_cmd;
                            ena_q      <= 1'b1;
                            state_q    <= ST_CMD_SEND;
                        end
                    end
                end
                ST_IDLE: begin
                    if (px_valid && ready_q) begin
                        ready_q    <= 1'b0;
                        spi_data_q <= px_data;
                        dc_q       <= 1'b1;
                        cs_q       <= 1'b0;
                        ena_q      <= 1'b1;
                        state_q    <= ST_DATA_SEND;
                    end
                end
                ST_DATA_SEND: begin
                    state_q <= ST_DATA_WAIT;
                end
                ST_DATA_WAIT: begin
                    if (spi_write_done) begin
                        if (byte_cnt_q == FRAME_TC) begin
                            byte_cnt_q   <= '0;
                            frame_done_q <= 1'b1;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + BYTE_CNT_W'(1);
                        end
                        ready_q <= 1'b1;
                        cs_q    <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_RES_LOW;
                end
            endcase
        end
    end

    assign px_ready      = ready_q;
    assign spi_ena_write = ena_q;
    assign spi_data      = spi_data_q;
    assign oled_res      = res_q;
    assign oled_dc       = dc_q;
    assign oled_cs       = cs_q;
    assign init_done     = init_done_q;
    assign frame_done    = frame_done_q;

endmodule
